// File: rtl/dmem_bridge_pkg.sv
// rtl/dmem_bridge_pkg.sv - state encoding, transfer sizes and timeout sizing for the data-memory SRAM bridge
package dmem_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } bridgeState_t;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   localparam int DEF_TIMEOUT_CYCLES = 255;
   localparam int TIMEOUT_W          = $clog2(DEF_TIMEOUT_CYCLES + 1);

endpackage

// File: rtl/dmem_strb_decode.sv
// rtl/dmem_strb_decode.sv - byte strobes to bus size, byte offset and write flag
module dmem_strb_decode
   import dmem_bridge_pkg::*;
(
   input  logic [3:0] wen,
   output logic [1:0] size,
   output logic [1:0] offset,
   output logic       wr
);

   // Zero strobes is a load; unexpected patterns fall back to a full word.
   always_comb begin
      size   = SIZE_WORD;
      offset = 2'd0;
      wr     = |wen;
      case (wen)
         4'b0001: begin size = SIZE_BYTE; offset = 2'd0; end
         4'b0010: begin size = SIZE_BYTE; offset = 2'd1; end
         4'b0100: begin size = SIZE_BYTE; offset = 2'd2; end
         4'b1000: begin size = SIZE_BYTE; offset = 2'd3; end
         4'b0011: begin size = SIZE_HALF; offset = 2'd0; end
         4'b1100: begin size = SIZE_HALF; offset = 2'd2; end
         default: begin size = SIZE_WORD; offset = 2'd0; end
      endcase
   end

endmodule

// File: rtl/dmem_sram_bridge.sv
// rtl/dmem_sram_bridge.sv - MEM-stage bridge from the byte-lane translator to an addr_ok/data_ok SRAM bus
// Optional timeout abort of a hung transaction is compiled in with DMEM_TIMEOUT_EN.
module dmem_sram_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemEnable,
   input  logic              MemWrite,
   input  logic [3:0]        MemWen,
   input  logic [ADDR_W-1:0] MemAddr,
   input  logic [DATA_W-1:0] TWriteData,
   output logic [DATA_W-1:0] ReadData,
   output logic              mem_stall,
   input  logic              pipe_go,
   input  logic              flush,
   output logic              bus_err,
   output logic              data_sram_req,
   output logic              data_sram_wr,
   output logic [1:0]        data_sram_size,
   output logic [ADDR_W-1:0] data_sram_addr,
   output logic [3:0]        data_sram_wstrb,
   output logic [DATA_W-1:0] data_sram_wdata,
   input  logic              data_sram_addr_ok,
   input  logic              data_sram_data_ok,
   input  logic [DATA_W-1:0] data_sram_rdata
);

   bridgeState_t state, stateNext;
   logic         drop, dropNow, busDone, timeoutHit;
   logic         capture, reqSet, reqClr, loadRead, clearRead, dropSet, dropClr;
   logic [3:0]   effWen;
   logic [1:0]   decSize, decOff;
   logic         decWr;
   logic         unusedBits;

   // Loads never drive strobes, whatever the translator leaves on MemWen.
   assign effWen = MemWrite ? MemWen : 4'b0000;

   dmem_strb_decode uStrbDecode (
      .wen    (effWen),
      .size   (decSize),
      .offset (decOff),
      .wr     (decWr)
   );

   assign dropNow    = drop || flush;
   assign busDone    = data_sram_data_ok &&
                       ((state == WAIT) || ((state == REQ) && data_sram_addr_ok));
   assign mem_stall  = MemEnable && (state != DONE) && !drop;
   assign unusedBits = ^{MemAddr[1:0], (TIMEOUT_CYCLES > 0)};

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] toCnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         toCnt   <= '0;
         bus_err <= 1'b0;
      end else begin
         bus_err <= timeoutHit;
         if (reqSet)
            toCnt <= '0;
         else if ((state == REQ) || (state == WAIT))
            toCnt <= toCnt + CNT_W'(1);
      end
   end

   assign timeoutHit = ((state == REQ) || (state == WAIT)) &&
                       (toCnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeoutHit = 1'b0;
   assign bus_err    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      capture   = 1'b0;
      reqSet    = 1'b0;
      reqClr    = 1'b0;
      loadRead  = 1'b0;
      clearRead = 1'b0;
      dropSet   = 1'b0;
      dropClr   = 1'b0;
      case (state)
         IDLE: begin
            if (MemEnable && !flush) begin
               capture = 1'b1;
               if (MemWrite && (MemWen == 4'b0000)) begin
                  stateNext = DONE;
               end else begin
                  stateNext = REQ;
                  reqSet    = 1'b1;
               end
            end
         end
         REQ, WAIT: begin
            // A flushed access still runs to completion on the bus; only its result is discarded.
            dropSet = flush;
            if (timeoutHit || busDone) begin
               reqClr    = 1'b1;
               dropClr   = dropNow;
               stateNext = dropNow ? IDLE : DONE;
               loadRead  = busDone && !timeoutHit && !dropNow && !data_sram_wr;
               clearRead = timeoutHit && !dropNow;
            end else if ((state == REQ) && data_sram_addr_ok) begin
               reqClr    = 1'b1;
               stateNext = WAIT;
            end
         end
         DONE: begin
            if (pipe_go || flush) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_sram_req   <= 1'b0;
         data_sram_wr    <= 1'b0;
         data_sram_size  <= 2'd0;
         data_sram_addr  <= '0;
         data_sram_wstrb <= 4'd0;
         data_sram_wdata <= '0;
         ReadData        <= '0;
         drop            <= 1'b0;
      end else begin
         if (capture) begin
            data_sram_wr    <= decWr;
            data_sram_size  <= decSize;
            data_sram_addr  <= {MemAddr[ADDR_W-1:2], decOff};
            data_sram_wstrb <= effWen;
            data_sram_wdata <= TWriteData;
         end
         if (reqSet)
            data_sram_req <= 1'b1;
         else if (reqClr)
            data_sram_req <= 1'b0;
         if (loadRead)
            ReadData <= data_sram_rdata;
         else if (clearRead)
            ReadData <= '0;
         if (dropClr)
            drop <= 1'b0;
         else if (dropSet)
            drop <= 1'b1;
      end
   end

endmodule
